tx_symbol_scheduler: RTL and testbench

- Transmit-side sequencer that drives the 8b/10b encoder's in_8b/dataK inputs with exactly one symbol per clock.
- Frames upstream packet bytes with STP/END, fills gaps with logical idle, and inserts periodic SKP ordered sets at packet boundaries for clock compensation.
- Aborts underrun packets with EDB.
- Sits between the link-layer TX byte stream and the encoder.

---
 rtl/tx_symbol_scheduler.sv | 151 +++++++++++++++
 tb/tb_tx_symbol_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_symbol_scheduler.sv
// ============================================================================
// tx_symbol_scheduler : frames TX bytes with STP/END, fills idle, inserts SKP
// Rev 1.0
// ============================================================================
`default_nettype none

module tx_symbol_scheduler #(
  parameter int SKP_INTERVAL = 64,
  parameter int SKP_COUNT    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pkt_data,
  input  logic       pkt_valid,
  input  logic       pkt_last,
  output logic       pkt_ready,
  output logic [7:0] out_8b,
  output logic       out_dataK,
  output logic       skp_active,
  output logic       underrun_err,
  output logic       skp_late
);

  localparam int            TW        = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(SKP_INTERVAL - 1);
  localparam logic [2:0]    SKP_LAST  = 3'(SKP_COUNT);

  localparam logic [7:0] SYM_IDL = 8'h00;
  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_SKP = 8'h1C;

  // S_EDB is the single cycle that drives EDB before the silent abort drain.
  typedef enum logic [2:0] {
    S_IDLE, S_STP, S_DATA, S_END, S_EDB, S_ABORT, S_COM, S_SKP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          last_taken_q, last_taken_d;
  logic [2:0]    skp_idx_q, skp_idx_d;
  logic [TW-1:0] skp_timer_q, skp_timer_d;
  logic          skp_pending_q, skp_pending_d;
  logic [7:0]    out_8b_q, out_8b_d;
  logic          out_dataK_q, out_dataK_d;
  logic          skp_active_q, skp_active_d;
  logic          underrun_err_q, underrun_err_d;
  logic          skp_late_q, skp_late_d;

  logic   xfer;
  logic   expire;
  state_t decision;

  always_comb begin
    pkt_ready = (state_q == S_STP) || (state_q == S_DATA && !last_taken_q) ||
                (state_q == S_ABORT);
    xfer      = pkt_valid && pkt_ready;
    // Packet boundaries are the only places a pending SKP may be inserted.
    decision  = skp_pending_q ? S_COM : (pkt_valid ? S_STP : S_IDLE);

    state_d      = state_q;
    data_d       = data_q;
    last_taken_d = last_taken_q;
    skp_idx_d    = skp_idx_q;

    case (state_q)
      S_IDLE, S_END: state_d = decision;
      S_STP, S_DATA: begin
        if (state_q == S_DATA && last_taken_q) begin
          state_d = S_END;
        end else if (xfer) begin
          state_d      = S_DATA;
          data_d       = pkt_data;
          last_taken_d = pkt_last;
        end else begin
          state_d = S_EDB;
        end
      end
      S_EDB:   state_d = S_ABORT;
      S_ABORT: if (xfer && pkt_last) state_d = S_IDLE;
      S_COM: begin
        state_d   = S_SKP;
        skp_idx_d = 3'd1;
      end
      S_SKP: begin
        if (skp_idx_q >= SKP_LAST) state_d = decision;
        else                       skp_idx_d = skp_idx_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase

    expire        = (skp_timer_q == TIMER_MAX);
    skp_timer_d   = expire ? '0 : skp_timer_q + 1'b1;
    // A fresh expiry wins over the clear caused by entering COM.
    skp_pending_d = expire || (skp_pending_q && state_d != S_COM);
    skp_late_d    = expire && skp_pending_q;

    out_8b_d    = SYM_IDL;
    out_dataK_d = 1'b0;
    case (state_d)
      S_STP:   begin out_8b_d = SYM_STP; out_dataK_d = 1'b1; end
      S_DATA:  out_8b_d = data_d;
      S_END:   begin out_8b_d = SYM_END; out_dataK_d = 1'b1; end
      S_EDB:   begin out_8b_d = SYM_EDB; out_dataK_d = 1'b1; end
      S_COM:   begin out_8b_d = SYM_COM; out_dataK_d = 1'b1; end
      S_SKP:   begin out_8b_d = SYM_SKP; out_dataK_d = 1'b1; end
      default: begin out_8b_d = SYM_IDL; out_dataK_d = 1'b0; end
    endcase
    skp_active_d   = (state_d == S_COM) || (state_d == S_SKP);
    underrun_err_d = (state_d == S_EDB);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      data_q         <= '0;
      last_taken_q   <= 1'b0;
      skp_idx_q      <= '0;
      skp_timer_q    <= '0;
      skp_pending_q  <= 1'b0;
      out_8b_q       <= '0;
      out_dataK_q    <= 1'b0;
      skp_active_q   <= 1'b0;
      underrun_err_q <= 1'b0;
      skp_late_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      data_q         <= data_d;
      last_taken_q   <= last_taken_d;
      skp_idx_q      <= skp_idx_d;
      skp_timer_q    <= skp_timer_d;
      skp_pending_q  <= skp_pending_d;
      out_8b_q       <= out_8b_d;
      out_dataK_q    <= out_dataK_d;
      skp_active_q   <= skp_active_d;
      underrun_err_q <= underrun_err_d;
      skp_late_q     <= skp_late_d;
    end
  end

  assign out_8b       = out_8b_q;
  assign out_dataK    = out_dataK_q;
  assign skp_active   = skp_active_q;
  assign underrun_err = underrun_err_q;
  assign skp_late     = skp_late_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_symbol_scheduler.sv
// ============================================================================
// tb_tx_symbol_scheduler : scoreboard bench, SKP_INTERVAL=32, SKP_COUNT=3
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tx_symbol_scheduler;

  localparam int SKP_INTERVAL = 32;
  localparam int SKP_COUNT    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pkt_data = 8'h00;
  logic       pkt_valid = 1'b0;
  logic       pkt_last = 1'b0;
  logic       pkt_ready;
  logic [7:0] out_8b;
  logic       out_dataK;
  logic       skp_active;
  logic       underrun_err;
  logic       skp_late;

  always #5 clk = ~clk;

  tx_symbol_scheduler #(.SKP_INTERVAL(SKP_INTERVAL), .SKP_COUNT(SKP_COUNT)) dut (
    .clk(clk), .reset(reset), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
    .pkt_last(pkt_last), .pkt_ready(pkt_ready), .out_8b(out_8b),
    .out_dataK(out_dataK), .skp_active(skp_active),
    .underrun_err(underrun_err), .skp_late(skp_late)
  );

  typedef struct {
    logic [7:0] sym;
    logic       k;
    logic       und;
    int         at;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] pk[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc;
  int late_cyc = -1;
  int ready_cnt = 0;

  // cyc = number of rising edges since reset release
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] sym, input logic k, input logic und, input int at);
    exp_t e;
    e.sym = sym; e.k = k; e.und = und; e.at = at;
    expq.push_back(e);
  endtask

  task automatic push_skp(input int base);
    push(8'hBC, 1'b1, 1'b0, base);
    for (int i = 1; i <= SKP_COUNT; i++) push(8'h1C, 1'b1, 1'b0, base + i);
  endtask

  task automatic wait_neg(input int n);
    while (cyc < n) @(negedge clk);
    chk("schedule_cycle", cyc, n);
  endtask

  // Offers pk[] byte by byte; returns on the falling edge after the last transfer.
  task automatic send(input bit mark_last);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < pk.size() && guard < 400) begin
      pkt_valid = 1'b1;
      pkt_data  = pk[i];
      pkt_last  = mark_last && (i == pk.size() - 1);
      if (pkt_ready) i++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got %0d of %0d bytes taken", i, pk.size());
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (cyc >= 70 && cyc <= 78 && pkt_ready) ready_cnt++;
      if (out_8b != 8'h00 || out_dataK) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_symbol: got %h K=%b at cyc %0d, expected idle", out_8b, out_dataK, cyc);
        end else begin
          e = expq.pop_front();
          if (out_8b !== e.sym || out_dataK !== e.k || underrun_err !== e.und ||
              skp_active !== (e.k && (e.sym == 8'hBC || e.sym == 8'h1C)) ||
              (e.at >= 0 && cyc != e.at)) begin
            miscompares++;
            $display("FAIL symbol: got %h K=%b und=%b skp=%b at cyc %0d, expected %h K=%b und=%b at cyc %0d",
                     out_8b, out_dataK, underrun_err, skp_active, cyc, e.sym, e.k, e.und, e.at);
          end
        end
      end else begin
        vectors++;
        if (skp_active !== 1'b0 || underrun_err !== 1'b0) begin
          miscompares++;
          $display("FAIL idle_flags: got skp_active=%b underrun_err=%b at cyc %0d, expected 0/0",
                   skp_active, underrun_err, cyc);
        end
      end
      if (cyc == late_cyc) begin
        vectors++;
        if (skp_late !== 1'b1) begin
          miscompares++;
          $display("FAIL skp_late_pulse: got %b at cyc %0d, expected 1", skp_late, cyc);
        end
      end else if (skp_late !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL skp_late_spurious: got 1 at cyc %0d, expected 0", cyc);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected end before 50000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    @(negedge clk);
    chk("reset_out_8b", out_8b, 0);
    chk("reset_dataK", out_dataK, 0);
    chk("reset_skp_active", skp_active, 0);
    chk("reset_underrun", underrun_err, 0);
    chk("reset_skp_late", skp_late, 0);
    chk("reset_ready", pkt_ready, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle link: SKP sets every 32 cycles
    push_skp(33);
    push_skp(65);

    // Single 3-byte packet
    pk = '{8'h11, 8'h22, 8'h33};
    push(8'hFB, 1, 0, 71); push(8'h11, 0, 0, 72); push(8'h22, 0, 0, 73);
    push(8'h33, 0, 0, 74); push(8'hFD, 1, 0, 75);
    wait_neg(70);
    send(1'b1);
    pkt_valid = 1'b0;

    // Back-to-back packets, no idle between END and STP
    push(8'hFB, 1, 0, 81); push(8'hAA, 0, 0, 82); push(8'hBB, 0, 0, 83);
    push(8'hFD, 1, 0, 84); push(8'hFB, 1, 0, 85); push(8'hCC, 0, 0, 86);
    push(8'hFD, 1, 0, 87);
    push_skp(97);
    wait_neg(80);
    chk("ready_cycles_3byte", ready_cnt, 3);
    pk = '{8'hAA, 8'hBB};
    send(1'b1);
    pk = '{8'hCC};
    send(1'b1);
    pkt_valid = 1'b0;

    // 40-byte packet spans an expiry; COM deferred to right after END
    pk.delete();
    push(8'hFB, 1, 0, 101);
    for (int i = 1; i <= 40; i++) begin
      pk.push_back(8'(i));
      push(8'(i), 0, 0, 101 + i);
    end
    push(8'hFD, 1, 0, 142);
    push_skp(143);
    push_skp(161);
    wait_neg(100);
    send(1'b1);
    pkt_valid = 1'b0;

    // 70-byte packet spans two expiries: late pulse on the second
    pk.delete();
    late_cyc = 224;
    push(8'hFB, 1, 0, 167);
    for (int i = 1; i <= 70; i++) begin
      pk.push_back(8'(i));
      push(8'(i), 0, 0, 167 + i);
    end
    push(8'hFD, 1, 0, 238);
    push_skp(239);
    push_skp(257);
    wait_neg(166);
    send(1'b1);
    pkt_valid = 1'b0;

    // Underrun after first byte, drain the rest silently, then a clean packet
    push(8'hFB, 1, 0, 263); push(8'h55, 0, 0, 264); push(8'hFE, 1, 1, 265);
    push(8'hFB, 1, 0, 271); push(8'h44, 0, 0, 272); push(8'hFD, 1, 0, 273);
    push(8'hBC, 1, 0, 289); push(8'h1C, 1, 0, 290); push(8'h1C, 1, 0, 291);
    wait_neg(262);
    pk = '{8'h55};
    send(1'b0);
    pkt_valid = 1'b0;
    wait_neg(266);
    pk = '{8'h66, 8'h77};
    send(1'b1);
    pkt_valid = 1'b0;
    wait_neg(270);
    pk = '{8'h44};
    send(1'b1);
    pkt_valid = 1'b0;

    // Asynchronous reset during the second SKP symbol
    wait_neg(291);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_out_8b", out_8b, 0);
    chk("async_reset_dataK", out_dataK, 0);
    chk("async_reset_skp_active", skp_active, 0);
    chk("async_reset_underrun", underrun_err, 0);
    chk("async_reset_skp_late", skp_late, 0);
    chk("queue_drained_pre_reset", expq.size(), 0);
    @(negedge clk);
    @(negedge clk);
    push_skp(33);
    reset = 1'b0;
    wait_neg(40);
    chk("queue_drained_final", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
